// File: rtl/tff_sync.sv
// tff_sync: bank of WIDTH independent toggle flip-flops with synchronous active-low reset
//   t   : per-bit toggle enable; 1 inverts that q bit at the next rising edge, 0 holds it
//   clk : rising-edge clock
//   rst : synchronous reset, active low; loads RESET_VAL and overrides t
//   q   : registered state, no combinational path from t or rst
module tff_sync #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic [WIDTH-1:0] t,
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] r_q;
    always_ff @(posedge clk) r_q <= !rst ? RESET_VAL : r_q ^ t;
    assign q = r_q;
endmodule

// File: tb/tb_tff_sync.sv
// tb_tff_sync: directed self-checking bench for a scalar and a 4-bit tff_sync instance
module tb_tff_sync;
    logic       clk = 1'b0;
    logic       rst1, t1, q1;
    logic       rst4;
    logic [3:0] t4, q4;
    int         total = 0;
    int         bad   = 0;

    tff_sync u_s (.t(t1), .clk(clk), .rst(rst1), .q(q1));
    tff_sync #(.WIDTH(4), .RESET_VAL(4'b1010)) u_v (.t(t4), .clk(clk), .rst(rst4), .q(q4));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    initial begin
        rst1 = 1'b0; t1 = 1'b1;
        rst4 = 1'b0; t4 = 4'b1111;
        tick();
        chk("rst_s_e1", {3'b0, q1}, 4'b0000);
        chk("rst_v_e1", q4, 4'b1010);
        tick();
        chk("rst_s_e2", {3'b0, q1}, 4'b0000);
        chk("rst_v_e2", q4, 4'b1010);
        rst4 = 1'b1; t4 = 4'b0110;
        tick();
        chk("vec_tog", q4, 4'b1100);
        t4 = 4'b0000;
        tick();
        chk("vec_hold1", q4, 4'b1100);
        tick();
        chk("vec_hold2", q4, 4'b1100);
        rst4 = 1'b0; t4 = 4'b1111;
        tick();
        chk("vec_rst_mid", q4, 4'b1010);
        chk("s_held_rst", {3'b0, q1}, 4'b0000);
        rst1 = 1'b1; t1 = 1'b1;
        tick(); chk("tog1", {3'b0, q1}, 4'b0001);
        tick(); chk("tog2", {3'b0, q1}, 4'b0000);
        tick(); chk("tog3", {3'b0, q1}, 4'b0001);
        tick(); chk("tog4", {3'b0, q1}, 4'b0000);
        tick(); chk("set1", {3'b0, q1}, 4'b0001);
        t1 = 1'b0;
        tick(); chk("hold1", {3'b0, q1}, 4'b0001);
        tick(); chk("hold2", {3'b0, q1}, 4'b0001);
        tick(); chk("hold3", {3'b0, q1}, 4'b0001);
        t1 = 1'b1;
        tick(); chk("hold_tog", {3'b0, q1}, 4'b0000);
        tick(); chk("set2", {3'b0, q1}, 4'b0001);
        t1 = 1'b0;
        #2 rst1 = 1'b0;
        #2 rst1 = 1'b1;
        chk("glitch_now", {3'b0, q1}, 4'b0001);
        tick(); chk("glitch_edge", {3'b0, q1}, 4'b0001);
        rst1 = 1'b0; t1 = 1'b1;
        tick(); chk("sync_rst", {3'b0, q1}, 4'b0000);
        tick(); chk("rst_hold", {3'b0, q1}, 4'b0000);
        rst1 = 1'b1;
        #2 chk("release_pre", {3'b0, q1}, 4'b0000);
        tick(); chk("release_tog", {3'b0, q1}, 4'b0001);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
